// File: rtl/synth_mem_pkg.sv
// Shared definitions for the synthesiser memory: address map used by both
// the filter and its memory responder, plus the host read FSM encoding.
package synth_mem_pkg;

  localparam int DEFAULT_ADDR_W = 16;

  localparam logic [15:0] SAMPLE_ADDR = 16'h0000;
  localparam logic [15:0] FILTER_ADDR = 16'h8000;

  typedef enum logic [0:0] {
    RD_IDLE = 1'b0,
    RD_WAIT = 1'b1
  } rd_state_e;

endpackage : synth_mem_pkg

// File: rtl/host_wr_fifo.sv
// Host write queue: DEPTH entries of {address, byte}, power-of-two depth so
// the pointers wrap by natural overflow.
module host_wr_fifo #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic [ADDR_W-1:0] push_addr_i,
  input  logic [7:0]        push_data_i,
  input  logic              pop_i,
  output logic              full_o,
  output logic              empty_o,
  output logic [ADDR_W-1:0] head_addr_o,
  output logic [7:0]        head_data_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [ADDR_W-1:0] addr_mem_q [0:DEPTH-1];
  logic [7:0]        data_mem_q [0:DEPTH-1];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic              push_ok_s, pop_ok_s;

  assign full_o      = (count_q == FULL_CNT);
  assign empty_o     = (count_q == (PTR_W + 1)'(0));
  assign push_ok_s   = push_i & ~full_o;
  assign pop_ok_s    = pop_i & ~empty_o;
  assign head_addr_o = addr_mem_q[rd_ptr_q];
  assign head_data_o = data_mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage carries no reset; validity is tracked by count_q alone.
  always_ff @(posedge clk_i) begin
    if (push_ok_s) begin
      addr_mem_q[wr_ptr_q] <= push_addr_i;
      data_mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule : host_wr_fifo

// File: rtl/filter_mem.sv
// Byte memory shared by the filter (same-cycle bus responder, absolute
// priority) and a host port with a queued write path and an ordered read path.
module filter_mem
  import synth_mem_pkg::*;
#(
  parameter int ADDR_W     = DEFAULT_ADDR_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [ADDR_W-1:0] MemAddr,
  inout  wire  [7:0]        MemData,
  input  logic              MemWrite,
  input  logic              HostWrValid,
  output logic              HostWrReady,
  input  logic [ADDR_W-1:0] HostWrAddr,
  input  logic [7:0]        HostWrData,
  input  logic              HostRdReq,
  input  logic [ADDR_W-1:0] HostRdAddr,
  output logic              HostRdValid,
  output logic [7:0]        HostRdData,
  output logic              HostBusy
);

  logic [7:0]        mem_q [0:(1 << ADDR_W) - 1];
  logic              fifo_full_s, fifo_empty_s;
  logic              push_s, pop_s;
  logic [ADDR_W-1:0] head_addr_s;
  logic [7:0]        head_data_s;
  rd_state_e         state_q, state_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              rd_valid_q, rd_valid_d;
  logic [7:0]        rd_data_q, rd_data_d;

  assign push_s = HostWrValid & ~fifo_full_s;
  // Reset must not let a queued entry slip into the array on its way out.
  assign pop_s  = ~fifo_empty_s & ~MemWrite & ~Reset;

  host_wr_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .ADDR_W (ADDR_W)
  ) u_host_wr_fifo (
    .clk_i       (Clock),
    .rst_i       (Reset),
    .push_i      (push_s),
    .push_addr_i (HostWrAddr),
    .push_data_i (HostWrData),
    .pop_i       (pop_s),
    .full_o      (fifo_full_s),
    .empty_o     (fifo_empty_s),
    .head_addr_o (head_addr_s),
    .head_data_o (head_data_s)
  );

  assign MemData = MemWrite ? 8'hzz : mem_q[MemAddr];

  // The filter write wins the single write port; the queue head waits.
  always_ff @(posedge Clock) begin
    if (MemWrite) begin
      mem_q[MemAddr] <= MemData;
    end else if (pop_s) begin
      mem_q[head_addr_s] <= head_data_s;
    end
  end

  // The read itself is taken on the edge that returns the FSM to IDLE, so an
  // uncontended request from IDLE completes without visiting WAIT. A push in
  // the request cycle is not yet in the array, so that case must wait.
  always_comb begin
    state_d    = state_q;
    rd_addr_d  = rd_addr_q;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    case (state_q)
      RD_IDLE: begin
        if (HostRdReq) begin
          rd_addr_d = HostRdAddr;
          if (fifo_empty_s && !push_s && !MemWrite) begin
            rd_valid_d = 1'b1;
            rd_data_d  = mem_q[HostRdAddr];
            state_d    = RD_IDLE;
          end else begin
            state_d = RD_WAIT;
          end
        end else begin
          state_d = RD_IDLE;
        end
      end
      RD_WAIT: begin
        if (fifo_empty_s && !MemWrite) begin
          rd_valid_d = 1'b1;
          rd_data_d  = mem_q[rd_addr_q];
          state_d    = RD_IDLE;
        end else begin
          state_d = RD_WAIT;
        end
      end
      default: begin
        state_d = RD_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= RD_IDLE;
      rd_addr_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      rd_addr_q  <= rd_addr_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign HostWrReady = ~fifo_full_s;
  assign HostRdValid = rd_valid_q;
  assign HostRdData  = rd_data_q;
  assign HostBusy    = ~fifo_empty_s | (state_q != RD_IDLE);

endmodule : filter_mem
